// File: rtl/div_harness_pkg.sv
// Shared types and helpers for the divider test harness: FSM states, LFSR taps,
// operand widths and the LFSR-word to {d, q, r} operand mapping.
package div_harness_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWait,
    StCheck,
    StNext,
    StDone
  } state_e;

  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  localparam int unsigned ResW = 8;
  localparam int unsigned OpW  = 16;
  localparam int unsigned BusW = 64;

  typedef struct packed {
    logic [ResW-1:0] d;
    logic [ResW-1:0] q;
    logic [ResW-1:0] r;
  } ops_t;

  // d has its MSB forced so it is never zero and r < 128 <= d always holds.
  function automatic ops_t derive_ops(logic [31:0] l);
    ops_t o;
    o.d = {1'b1, l[6:0]};
    o.q = l[15:8];
    o.r = {1'b0, l[22:16]};
    return o;
  endfunction

endpackage

// File: rtl/div_lfsr32.sv
// 32-bit right-shifting Galois LFSR with synchronous load (priority) and advance.
module div_lfsr32 #(
  parameter logic [31:0] Seed = 32'hACE1_0001
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [31:0] state_o
);
  import div_harness_pkg::*;

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = Seed;
    end else if (adv_i) begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/div_req_checker.sv
// Self-checking divider initiator: issues LFSR-derived operand sets with known answers and
// counts mismatches, timeouts and spurious results. Define DIVCHK_STOP_ON_ERR_EN to stop on error.
module div_req_checker
  import div_harness_pkg::*;
#(
  parameter int unsigned NUM_OPS = 256,
  parameter int unsigned TIMEOUT = 64,
  parameter logic [31:0] SEED    = 32'hACE1_0001
) (
  input  logic              CCLK,
  input  logic              CRESET_N,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       op_count,
  output logic [7:0]        err_count,
  output logic [7:0]        spurious,
  output logic [BusW-1:0]   Dividend_hi,
  output logic [BusW-1:0]   Dividend_lo,
  output logic [BusW-1:0]   Divisor,
  output logic              SSE,
  output logic              i_valid,
  input  logic [ResW-1:0]   quotient,
  input  logic [ResW-1:0]   remainder,
  input  logic              DivResult
);

  state_e          state_q, state_d;
  logic [15:0]     op_count_q, op_count_d;
  logic [7:0]      err_q, err_d;
  logic [7:0]      spur_q, spur_d;
  logic [7:0]      tmo_q, tmo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ivalid_q, ivalid_d;
  logic [ResW-1:0] divisor_q, divisor_d;
  logic [OpW-1:0]  dividend_q, dividend_d;
  logic [ResW-1:0] expq_q, expq_d, expr_q, expr_d;
  logic [ResW-1:0] capq_q, capq_d, capr_q, capr_d;
  logic            start_ok, err_inc;
  logic [31:0]     lfsr;
  ops_t            ops;

  assign start_ok = start && (state_q == StIdle || state_q == StDone);
  assign ops      = derive_ops(lfsr);

  div_lfsr32 #(
    .Seed(SEED)
  ) u_lfsr (
    .clk_i  (CCLK),
    .rst_ni (CRESET_N),
    .load_i (start_ok),
    .adv_i  (state_q == StIssue),
    .state_o(lfsr)
  );

  always_comb begin
    state_d    = state_q;
    op_count_d = op_count_q;
    err_d      = err_q;
    spur_d     = spur_q;
    tmo_d      = tmo_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ivalid_d   = 1'b0;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    expq_d     = expq_q;
    expr_d     = expr_q;
    capq_d     = capq_q;
    capr_d     = capr_q;
    err_inc    = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLoad;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          op_count_d = '0;
          err_d      = '0;
          spur_d     = '0;
        end
      end
      StLoad: begin
        divisor_d  = ops.d;
        dividend_d = OpW'(ops.q) * OpW'(ops.d) + OpW'(ops.r);
        expq_d     = ops.q;
        expr_d     = ops.r;
        ivalid_d   = 1'b1;
        state_d    = StIssue;
      end
      StIssue: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A response arriving on the final WAIT cycle wins over the timeout.
        if (DivResult) begin
          capq_d  = quotient;
          capr_d  = remainder;
          state_d = StCheck;
        end else if (tmo_q == 8'(TIMEOUT - 1)) begin
          err_inc = 1'b1;
          state_d = StNext;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StCheck: begin
        err_inc = (capq_q != expq_q) || (capr_q != expr_q);
        state_d = StNext;
      end
      StNext: begin
        op_count_d = op_count_q + 16'd1;
        if (op_count_d == 16'(NUM_OPS)) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase

    if (err_inc) begin
      if (err_d != 8'hFF) err_d = err_d + 8'd1;
`ifdef DIVCHK_STOP_ON_ERR_EN
      // Skip NEXT so op_count still indexes the failing operation.
      state_d = StDone;
      busy_d  = 1'b0;
      done_d  = 1'b1;
`endif
    end

    if (DivResult && state_q != StWait && spur_d != 8'hFF) begin
      spur_d = spur_d + 8'd1;
    end
  end

  always_ff @(posedge CCLK or negedge CRESET_N) begin
    if (!CRESET_N) begin
      state_q    <= StIdle;
      op_count_q <= '0;
      err_q      <= '0;
      spur_q     <= '0;
      tmo_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ivalid_q   <= 1'b0;
      divisor_q  <= '0;
      dividend_q <= '0;
      expq_q     <= '0;
      expr_q     <= '0;
      capq_q     <= '0;
      capr_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_count_q <= op_count_d;
      err_q      <= err_d;
      spur_q     <= spur_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ivalid_q   <= ivalid_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      expq_q     <= expq_d;
      expr_q     <= expr_d;
      capq_q     <= capq_d;
      capr_q     <= capr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = done_q && (err_q == 8'd0) && (spur_q == 8'd0);
  assign op_count    = op_count_q;
  assign err_count   = err_q;
  assign spurious    = spur_q;
  assign i_valid     = ivalid_q;
  assign Dividend_hi = '0;
  assign Dividend_lo = {{(BusW - OpW){1'b0}}, dividend_q};
  assign Divisor     = {{(BusW - ResW){1'b0}}, divisor_q};
  assign SSE         = 1'b0;

endmodule

// File: tb/tb_div_req_checker.sv
// Bench for div_req_checker: a behavioural divider with per-op latency/corruption tables and
// an arithmetic operand model derived from the seed.
module tb_div_req_checker;

  localparam int unsigned NOps = 6;
  localparam int unsigned Tmo  = 10;
  localparam logic [31:0] Seed = 32'hACE1_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        div_result = 1'b0;
  logic [7:0]  quo = 8'd0;
  logic [7:0]  rem = 8'd0;
  logic        busy, done, pass, sse, i_valid;
  logic [15:0] op_count;
  logic [7:0]  err_count, spurious;
  logic [63:0] dvd_hi, dvd_lo, dvs;

  always #5 clk = ~clk;

  div_req_checker #(
    .NUM_OPS(NOps),
    .TIMEOUT(Tmo),
    .SEED   (Seed)
  ) dut (
    .CCLK       (clk),
    .CRESET_N   (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .op_count   (op_count),
    .err_count  (err_count),
    .spurious   (spurious),
    .Dividend_hi(dvd_hi),
    .Dividend_lo(dvd_lo),
    .Divisor    (dvs),
    .SSE        (sse),
    .i_valid    (i_valid),
    .quotient   (quo),
    .remainder  (rem),
    .DivResult  (div_result)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected operands per op index, from the seed by plain arithmetic.
  int m_dvs[NOps];
  int m_dvd[NOps];
  int lat_tab[NOps];
  bit bad_tab[NOps];
  bit badq_tab[NOps];
  bit never_resp = 1'b0;
  int run_gen = 0;

  // Responder state, owned by the responder process.
  int         idx = 0;
  int         last_gen = 0;
  int         last_issue = 0;
  bit         pend = 1'b0;
  int         cnt = 0;
  logic [7:0] rq, rr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (((l % 2) == 1) ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic int gap_exp(input int i);
    if (never_resp || lat_tab[i] >= int'(Tmo)) return int'(Tmo) + 3;
    return lat_tab[i] + 5;
  endfunction

  // Divider model: answers lat_tab[i] cycles after the first WAIT cycle.
  always @(negedge clk) begin
    if (run_gen != last_gen) begin
      last_gen = run_gen;
      idx      = 0;
    end
    div_result = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        div_result = 1'b1;
        quo        = rq;
        rem        = rr;
        pend       = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
    if (i_valid === 1'b1) begin
      if (idx < int'(NOps)) begin
        chk("divisor", dvs, 64'(m_dvs[idx]));
        chk("dividend", dvd_lo, 64'(m_dvd[idx]));
        chk("dvd_hi_sse", {dvd_hi[62:0], sse}, 64'd0);
        if (idx > 0) chk("issue_gap", 64'(cyc - last_issue), 64'(gap_exp(idx - 1)));
        rq = 8'(dvd_lo[15:0] / {8'd0, dvs[7:0]});
        rr = 8'(dvd_lo[15:0] % {8'd0, dvs[7:0]});
        if (bad_tab[idx]) begin
          if (badq_tab[idx]) rq = rq + 8'd1;
          else rr = rr + 8'd1;
        end
        if (!never_resp) begin
          pend = 1'b1;
          cnt  = lat_tab[idx];
        end
      end else begin
        chk("issue_count", 64'(idx), 64'(NOps - 1));
      end
      last_issue = cyc;
      idx++;
    end
  end

  task automatic set_ideal();
    never_resp = 1'b0;
    for (int i = 0; i < int'(NOps); i++) begin
      lat_tab[i]  = 0;
      bad_tab[i]  = 1'b0;
      badq_tab[i] = 1'b0;
    end
  endtask

  task automatic run_start();
    run_gen++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {59'd0, busy, done, pass, i_valid, sse}, 64'd0);
    chk({tag, "_counts"}, {32'd0, op_count, err_count, spurious}, 64'd0);
    chk({tag, "_ops"}, dvd_lo | dvs | dvd_hi, 64'd0);
  endtask

  initial begin
    logic [31:0] l;
    int          exp_err;
    int          n;

    l = Seed;
    for (int i = 0; i < int'(NOps); i++) begin
      m_dvs[i] = 128 + int'(l % 128);
      m_dvd[i] = int'((l >> 8) % 256) * m_dvs[i] + int'((l >> 16) % 128);
      l        = lfsr_next(l);
    end
    set_ideal();

    // Reset state
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal divider, one-cycle answer
    run_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("ivalid_in_load", 64'(i_valid), 64'd0);
    @(negedge clk);
    chk("ivalid_in_issue", 64'(i_valid), 64'd1);
    wait_done(400);
    chk("ideal_pass", 64'(pass), 64'd1);
    chk("ideal_ops", 64'(op_count), 64'(NOps));
    chk("ideal_err", 64'(err_count), 64'd0);
    chk("ideal_busy", 64'(busy), 64'd0);
    chk("ideal_issued", 64'(idx), 64'(NOps));

    // Random latency (up to the last WAIT cycle) and random corruption, started from DONE
    exp_err = 0;
    for (int i = 0; i < int'(NOps); i++) begin
      lat_tab[i]  = int'($urandom_range(0, Tmo - 1));
      bad_tab[i]  = ($urandom_range(0, 2) == 0);
      badq_tab[i] = $urandom_range(0, 1) == 1;
    end
    bad_tab[1]            = 1'b1;
    badq_tab[1]           = 1'b0;
    lat_tab[NOps - 1]     = int'(Tmo) - 1;
    for (int i = 0; i < int'(NOps); i++) exp_err += int'(bad_tab[i]);
    run_start();
    wait_done(600);
    chk("rand_err", 64'(err_count), 64'(exp_err));
    chk("rand_ops", 64'(op_count), 64'(NOps));
    chk("rand_pass", 64'(pass), 64'd0);
    chk("rand_spur", 64'(spurious), 64'd0);

    // No response at all: every op times out
    set_ideal();
    never_resp = 1'b1;
    run_start();
    wait_done(600);
    chk("tmo_err", 64'(err_count), 64'(NOps));
    chk("tmo_ops", 64'(op_count), 64'(NOps));
    chk("tmo_spur", 64'(spurious), 64'd0);

    // Answers arrive after the timeout and land outside WAIT
    set_ideal();
    for (int i = 0; i < int'(NOps); i++) lat_tab[i] = 11;
    run_start();
    wait_done(600);
    repeat (20) @(negedge clk);
    chk("late_err", 64'(err_count), 64'(NOps));
    chk("late_spur", 64'(spurious), 64'(NOps));
    chk("late_pass", 64'(pass), 64'd0);

    // Reset asserted during WAIT of op 3, then a fresh run from the seed
    set_ideal();
    never_resp = 1'b1;
    run_start();
    n = 0;
    while (idx < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_op3", 64'(idx), 64'd3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    set_ideal();
    @(negedge clk);
    run_start();
    wait_done(400);
    chk("rerun_pass", 64'(pass), 64'd1);
    chk("rerun_ops", 64'(op_count), 64'(NOps));

    // start held high: ignored while busy, restarts only from DONE
    run_gen++;
    start = 1'b1;
    @(negedge clk);
    wait_done(400);
    chk("held_ops", 64'(op_count), 64'(NOps));
    chk("held_issued", 64'(idx), 64'(NOps));
    chk("held_pass", 64'(pass), 64'd1);
    run_gen++;
    @(negedge clk);
    start = 1'b0;
    chk("restart_cleared", {47'd0, op_count, done}, 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    wait_done(400);
    chk("restart_pass", 64'(pass), 64'd1);
    chk("restart_ops", 64'(op_count), 64'(NOps));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
